fifo_cmd_writer: RTL and testbench
==================================

// Module: fifo_cmd_writer
// PURPOSE
//  Producer end of the external 8-bit command FIFO link between the host and the display device.
//  Accepts command bytes on an internal valid/ready port and buffers them in a small queue.
//  Writes them into the external FIFO with an active-low write strobe.
//  Never starts a write while the FIFO reports full.
//  Sits in the host-side ice40 design, driving the FIFO write port and data bus.
// PARAMETERS
//  DEPTH          4  internal queue depth in bytes; power of 2, >= 2
//  SETUP_CYCLES   2  clocks data is driven before the strobe falls; >= 1
//  STROBE_CYCLES  3  clocks fifo_nwr is held low; >= 1
//  RECOVER_CYCLES 3  clocks after the strobe rises before the next full check; >= 3
// PORTS
//  clk        in   1     single system clock
//  nrst       in   1     reset, asynchronous, active-low
//  cmd_data   in   8     command byte to send
//  cmd_valid  in   1     cmd_data is valid
//  cmd_ready  out  1     queue can accept a byte this cycle
//  nff_in     in   1     FIFO full flag, active-low, asynchronous to clk
//  fifo_data  out  8     FIFO data bus
//  fifo_oe    out  1     1 = drive fifo_data onto the bus
//  fifo_nwr   out  1     FIFO write strobe, active-low
//  busy       out  1     queue non-empty or a write is in progress
//  count      out  CW    bytes queued, CW = $clog2(DEPTH)+1
// BEHAVIOUR
//  Reset (nrst=0, takes effect immediately):
//   - Outputs: fifo_nwr=1, fifo_oe=0, fifo_data=0, cmd_ready=0, busy=0, count=0.
//   - Internal: queue emptied, state=IDLE.
//   - Reset asserted mid-strobe forces fifo_nwr high at once; the interrupted byte is lost.
//  cmd_ready is registered.
//   - It is 1 from the first clock after reset release whenever count < DEPTH.
//   - It is 0 when count == DEPTH.
//  Push: a byte is enqueued on a clock edge where cmd_valid & cmd_ready.
//  Full-flag synchronisation:
//   - nff_in passes through a 2-flop synchroniser; nff_s is the synchronised value.
//   - nff_s is reset to 0 (treated as full until two clocks after release).
//  FSM:
//   IDLE:    if count != 0 && nff_s == 1, latch the queue head into fifo_data,
//            set fifo_oe=1 and go to SETUP. Otherwise stay.
//   SETUP:   hold for SETUP_CYCLES clocks, then drive fifo_nwr=0 and go to STROBE.
//   STROBE:  hold fifo_nwr=0 for exactly STROBE_CYCLES clocks.
//            Then drive fifo_nwr=1, pop the queue head (count-1) and go to RECOVER.
//   RECOVER: keep fifo_data and fifo_oe stable for RECOVER_CYCLES clocks.
//            Then drop fifo_oe to 0 and return to IDLE.
//  Data stability:
//   - fifo_data is constant from SETUP entry until RECOVER exit.
//   - The strobe never glitches; fifo_nwr is driven directly from a flop.
//  Full handling:
//   - nff_s is sampled only in IDLE.
//   - Full asserting during SETUP/STROBE does not abort the write; the strobe completes.
//   - RECOVER_CYCLES >= 3 guarantees that a full flag caused by this write is visible
//     before the next IDLE decision.
//  Timing:
//   - Minimum byte period is 1+SETUP+STROBE+RECOVER clocks (9 at defaults).
//   - Latency from push to strobe fall is 1+SETUP clocks, given an empty queue, IDLE and not full.
//  Simultaneous push and pop on one edge: count unchanged, both take effect.
//   - A push to a full queue cannot occur, because cmd_ready=0.
//  Pointers are CW-1 bits wide and wrap modulo DEPTH.
//   - count == DEPTH is distinguished from empty by count, not by the pointers.
//  busy = (count != 0) | (state != IDLE).
// STRUCTURE
//  Shared package icevga_pkg holds:
//   - FSM state encodings (2 bits: IDLE, SETUP, STROBE, RECOVER).
//   - CMD_W = 8.
//  Sub-module cmd_queue: synchronous DEPTH x 8 FIFO.
//   - Ports: push/pop/head/count; first-word-fall-through head.
//  Phase timing uses one down-counter, wide enough for the maximum of the three
//  cycle parameters, reloaded on each state change.
// TESTING
//  1. Reset with nff_in=1, push 0xA5 once:
//     fifo_oe rises 1 clk later; fifo_nwr is low for exactly 3 clks starting 3 clks after push;
//     fifo_data=0xA5 throughout; count returns to 0.
//  2. Burst-push 0x01..0x06 with cmd_valid held:
//     cmd_ready drops once 4 bytes are queued; all 6 bytes appear on the strobe in order;
//     strobe falls are 9 clks apart.
//  3. Hold nff_in=0, push 3 bytes; no strobe occurs.
//     Release nff_in=1: first strobe falls 2+1+2 clks later (sync, IDLE, SETUP).
//  4. Assert nff_in=0 during STROBE of byte 1 of 2: byte 1 strobe completes;
//     byte 2 is not written until nff_in returns high.
//  5. Pulse nrst low mid-STROBE: fifo_nwr=1 and fifo_oe=0 immediately; count=0;
//     no strobe after release until a new push.
//  6. Push and pop on the same edge with count=2: count stays 2; byte order is preserved.

Source files
------------

// File: rtl/icevga_pkg.sv
// Shared definitions for the host-side display link: command width and
// the write-strobe sequencer state encoding.
package icevga_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } wr_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cmd_queue.sv
// Small synchronous command byte queue with first-word-fall-through head.
// Full and empty are told apart by the occupancy count, not the pointers.
module cmd_queue
    import icevga_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [CMD_W-1:0] push_data,
    input  logic             pop,
    output logic [CMD_W-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int PW = CW - 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_cmd_writer.sv
// Producer side of the external 8-bit command FIFO: queues command bytes and
// writes them out with a setup / strobe / recover sequence gated by the full flag.
module fifo_cmd_writer
    import icevga_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 3,
    parameter int RECOVER_CYCLES = 3,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             nff_in,
    output logic [CMD_W-1:0] fifo_data,
    output logic             fifo_oe,
    output logic             fifo_nwr,
    output logic             busy,
    output logic [CW-1:0]    count
);

    localparam int TMAX = max3(SETUP_CYCLES, STROBE_CYCLES, RECOVER_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_SETUP   = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] T_STROBE  = TW'(STROBE_CYCLES - 1);
    localparam logic [TW-1:0] T_RECOVER = TW'(RECOVER_CYCLES - 1);

    wr_state_t        state;
    logic [TW-1:0]    timer;
    logic             nff_p0;
    logic             nff_s;
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] head;
    logic [CW-1:0]    count_next;

    assign push = cmd_valid & cmd_ready;
    assign pop  = (state == ST_STROBE) && (timer == '0);

    cmd_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .nrst     (nrst),
        .push     (push),
        .push_data(cmd_data),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Full flag crosses from the FIFO's domain; reset value reads as full.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nff_p0 <= 1'b0;
            nff_s  <= 1'b0;
        end else begin
            nff_p0 <= nff_in;
            nff_s  <= nff_p0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= (count_next < CW'(DEPTH));
        end
    end

    // One shared down-counter times every phase; it is reloaded on each transition.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            fifo_nwr  <= 1'b1;
            fifo_oe   <= 1'b0;
            fifo_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((count != '0) && nff_s) begin
                        fifo_data <= head;
                        fifo_oe   <= 1'b1;
                        timer     <= T_SETUP;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer == '0) begin
                        fifo_nwr <= 1'b0;
                        timer    <= T_STROBE;
                        state    <= ST_STROBE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_STROBE: begin
                    if (timer == '0) begin
                        fifo_nwr <= 1'b1;
                        timer    <= T_RECOVER;
                        state    <= ST_RECOVER;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_RECOVER: begin
                    if (timer == '0) begin
                        fifo_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (count != '0) | (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_cmd_writer.sv
// Randomised and directed bench for fifo_cmd_writer against a per-write
// timeline model of the queue, full-flag synchroniser and strobe sequence.
module tb_fifo_cmd_writer;

    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int ST    = 3;
    localparam int R     = 3;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [7:0]    cmd_data = 8'h00;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          nff_in = 1'b1;
    logic [7:0]    fifo_data;
    logic          fifo_oe;
    logic          fifo_nwr;
    logic          busy;
    logic [CW-1:0] count;

    fifo_cmd_writer #(
        .DEPTH(DEPTH), .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .RECOVER_CYCLES(R)
    ) dut (
        .clk(clk), .nrst(nrst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .nff_in(nff_in), .fifo_data(fifo_data),
        .fifo_oe(fifo_oe), .fifo_nwr(fifo_nwr), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int tcnt = 0;

    always @(posedge clk) tcnt <= tcnt + 1;

    // Reference: each write is a timeline measured from the edge it leaves idle.
    logic [7:0]    mq[$];
    bit            m_active;
    int            m_k;
    bit            m_nff_p, m_nff_s;
    logic          m_ready, m_nwr, m_oe, m_busy;
    logic [7:0]    m_data;
    logic [CW-1:0] m_count;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            m_active = 0; m_k = 0; m_nff_p = 0; m_nff_s = 0;
            m_ready = 0; m_data = 8'h00;
        end else begin
            bit take;
            take = cmd_valid && m_ready;
            if (m_active) begin
                m_k++;
                if (m_k == S + ST) void'(mq.pop_front());
                if (m_k == S + ST + R) m_active = 0;
            end else if (mq.size() > 0 && m_nff_s) begin
                m_active = 1; m_k = 0; m_data = mq[0];
            end
            if (take) mq.push_back(cmd_data);
            m_nff_s = m_nff_p;
            m_nff_p = nff_in;
            m_ready = (mq.size() < DEPTH);
        end
        m_oe    = m_active;
        m_nwr   = !(m_active && m_k >= S && m_k < S + ST);
        m_busy  = (mq.size() != 0) || m_active;
        m_count = CW'(mq.size());
    end

    wire  [14:0] dut_vec = {fifo_nwr, fifo_oe, fifo_data, cmd_ready, busy, count};
    logic [14:0] exp_vec;
    always @* exp_vec = {m_nwr, m_oe, m_data, m_ready, m_busy, m_count};

    // Write monitor: strobe fall cycles, bytes on the bus at the fall, low length.
    logic       prev_nwr = 1'b1;
    int         falls[$];
    logic [7:0] wbytes[$];
    int         low_len = 0;
    int         last_low = 0;

    always @(negedge clk) begin
        if (prev_nwr && !fifo_nwr) begin
            falls.push_back(tcnt);
            wbytes.push_back(fifo_data);
            low_len = 1;
        end else if (!fifo_nwr) begin
            low_len++;
        end else if (!prev_nwr) begin
            last_low = low_len;
        end
        prev_nwr = fifo_nwr;
    end

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (dut_vec !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", dut_vec, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0});
        end
        nrst = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int nf, push_edge, oe_rise;
        nf = falls.size();
        oe_rise = -1;
        cmd_valid = 1'b1; cmd_data = 8'hA5;
        push_edge = tcnt + 1;
        repeat (14) begin
            @(negedge clk); #1;
            cmd_valid = 1'b0;
            if (fifo_oe === 1'b1 && oe_rise < 0) oe_rise = tcnt;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (oe_rise !== push_edge + 1) begin
            n_fail++;
            $display("FAIL single_oe_rise: got %0d want %0d", oe_rise, push_edge + 1);
        end
        n_chk++;
        if (falls.size() != nf + 1) begin
            n_fail++;
            $display("FAIL single_strobes: got %0d want %0d", falls.size() - nf, 1);
        end else begin
            n_chk++;
            if (falls[nf] != push_edge + 1 + S) begin
                n_fail++;
                $display("FAIL single_latency: got %0d want %0d", falls[nf] - push_edge, 1 + S);
            end
            n_chk++;
            if (wbytes[nf] !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_data: got %h want a5", wbytes[nf]);
            end
        end
        n_chk++;
        if (last_low != ST || count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_len_count: got %0d/%0d want %0d/0", last_low, count, ST);
        end
    endtask

    task automatic test_burst();
        int nf, idx;
        bit rdy_prev, saw_full;
        nf = falls.size();
        idx = 1; saw_full = 0;
        cmd_valid = 1'b1; cmd_data = 8'h01;
        rdy_prev = cmd_ready;
        repeat (80) begin
            @(negedge clk); #1;
            if (cmd_valid && rdy_prev) idx++;
            if (count === 3'd4 && cmd_ready === 1'b0) saw_full = 1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL burst cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
            if (idx > 6) cmd_valid = 1'b0;
            else cmd_data = 8'(idx);
            rdy_prev = cmd_ready;
        end
        n_chk++;
        if (!saw_full) begin
            n_fail++;
            $display("FAIL burst_ready_drop: got no full-queue backpressure want ready=0 at count 4");
        end
        n_chk++;
        if (falls.size() != nf + 6) begin
            n_fail++;
            $display("FAIL burst_strobes: got %0d want 6", falls.size() - nf);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (wbytes[nf + i] !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL burst_order[%0d]: got %h want %h", i, wbytes[nf + i], 8'(i + 1));
                end
                if (i > 0) begin
                    n_chk++;
                    if (falls[nf + i] - falls[nf + i - 1] != 1 + S + ST + R) begin
                        n_fail++;
                        $display("FAIL burst_period[%0d]: got %0d want %0d", i,
                                 falls[nf + i] - falls[nf + i - 1], 1 + S + ST + R);
                    end
                end
            end
        end
    endtask

    task automatic test_full_hold();
        int nf, rel;
        nff_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        nf = falls.size();
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_data = 8'h31 + 8'(i);
            @(negedge clk); #1;
        end
        cmd_valid = 1'b0;
        repeat (20) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL hold cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() != nf || count !== 3'd3) begin
            n_fail++;
            $display("FAIL hold_no_write: got %0d strobes count %0d want 0 strobes count 3", falls.size() - nf, count);
        end
        nff_in = 1'b1;
        rel = tcnt;
        repeat (35) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL hold_release cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() != nf + 3) begin
            n_fail++;
            $display("FAIL hold_strobes: got %0d want 3", falls.size() - nf);
        end else begin
            n_chk++;
            if (falls[nf] != rel + 2 + 1 + S) begin
                n_fail++;
                $display("FAIL hold_release_latency: got %0d want %0d", falls[nf] - rel, 3 + S);
            end
            n_chk++;
            if ({wbytes[nf], wbytes[nf + 1], wbytes[nf + 2]} !== 24'h313233) begin
                n_fail++;
                $display("FAIL hold_order: got %h%h%h want 313233", wbytes[nf], wbytes[nf + 1], wbytes[nf + 2]);
            end
        end
    endtask

    task automatic test_full_mid();
        int nf, lim;
        nf = falls.size();
        cmd_valid = 1'b1;
        cmd_data = 8'h41; @(negedge clk); #1;
        cmd_data = 8'h42; @(negedge clk); #1;
        cmd_valid = 1'b0;
        lim = 0;
        while (fifo_nwr !== 1'b0 && lim < 20) begin
            @(negedge clk); #1;
            lim++;
        end
        n_chk++;
        if (fifo_nwr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_strobe: got nwr=%b want 0 within 20 cycles", fifo_nwr);
        end
        nff_in = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mid_full cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() != nf + 1 || last_low != ST) begin
            n_fail++;
            $display("FAIL mid_first_only: got %0d strobes len %0d want 1 strobe len %0d",
                     falls.size() - nf, last_low, ST);
        end
        nff_in = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mid_resume cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() != nf + 2 || wbytes[falls.size() - 1] !== 8'h42) begin
            n_fail++;
            $display("FAIL mid_second: got %0d strobes want 2 ending in byte 42", falls.size() - nf);
        end
    endtask

    task automatic test_reset_mid();
        int nf, lim;
        cmd_valid = 1'b1; cmd_data = 8'h55;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        lim = 0;
        while (fifo_nwr !== 1'b0 && lim < 20) begin
            @(negedge clk); #1;
            lim++;
        end
        @(negedge clk); #1;
        n_chk++;
        if (fifo_nwr !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_in_strobe: got nwr=%b want 0", fifo_nwr);
        end
        nrst = 1'b0;
        #1;
        n_chk++;
        if ({fifo_nwr, fifo_oe, count, busy} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_immediate: got nwr=%b oe=%b count=%0d busy=%b want 1 0 0 0",
                     fifo_nwr, fifo_oe, count, busy);
        end
        repeat (2) @(negedge clk);
        #1;
        nrst = 1'b1;
        nf = falls.size();
        repeat (20) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rmid_after cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() != nf) begin
            n_fail++;
            $display("FAIL rmid_no_strobe: got %0d strobes want 0", falls.size() - nf);
        end
    endtask

    task automatic test_push_pop();
        int nf, lim;
        nff_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        nf = falls.size();
        cmd_valid = 1'b1;
        cmd_data = 8'h61; @(negedge clk); #1;
        cmd_data = 8'h62; @(negedge clk); #1;
        cmd_valid = 1'b0;
        nff_in = 1'b1;
        lim = 0;
        while (fifo_nwr !== 1'b0 && lim < 20) begin
            @(negedge clk); #1;
            lim++;
        end
        n_chk++;
        if (fifo_nwr !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_wait_strobe: got nwr=%b want 0 within 20 cycles", fifo_nwr);
        end
        repeat (ST - 1) @(negedge clk);
        #1;
        cmd_valid = 1'b1; cmd_data = 8'h63;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        n_chk++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL pp_count: got %0d want 2", count);
        end
        repeat (30) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL pp cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() != nf + 3 ||
            {wbytes[nf], wbytes[nf + 1], wbytes[nf + 2]} !== 24'h616263) begin
            n_fail++;
            $display("FAIL pp_order: got %0d strobes want 3 bytes 61 62 63", falls.size() - nf);
        end
    endtask

    task automatic test_random();
        int nf;
        bit rdy_prev;
        logic [7:0] data_prev;
        logic [7:0] acc[$];
        nf = falls.size();
        rdy_prev = cmd_ready; data_prev = cmd_data;
        repeat (600) begin
            @(negedge clk); #1;
            if (cmd_valid && rdy_prev) acc.push_back(data_prev);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) nff_in = ~nff_in;
            rdy_prev = cmd_ready; data_prev = cmd_data;
        end
        if (cmd_valid && rdy_prev) acc.push_back(data_prev);
        @(negedge clk); #1;
        cmd_valid = 1'b0; nff_in = 1'b1;
        repeat (60) begin
            @(negedge clk); #1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_drain cyc %0d: got %h want %h", tcnt, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (falls.size() - nf != acc.size()) begin
            n_fail++;
            $display("FAIL random_write_count: got %0d want %0d", falls.size() - nf, acc.size());
        end else begin
            for (int i = 0; i < acc.size(); i++) begin
                n_chk++;
                if (wbytes[nf + i] !== acc[i]) begin
                    n_fail++;
                    $display("FAIL random_order[%0d]: got %h want %h", i, wbytes[nf + i], acc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_hold();
        test_full_mid();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
